// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: os_tick every act_int + act_frac/2^FRAC_W cycles
// on average, baudtick on every OVS-th os_tick, with glitch-free divisor updates.
module baud_gen_frac #(
  parameter int CNT_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int OVS        = 16,
  parameter int RESET_DIV  = 163,
  parameter int RESET_FRAC = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic              div_wr,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick,
  output logic              baudtick,
  output logic [CNT_W-1:0]  div_active,
  output logic              div_err
);

  localparam int OS_W = (OVS > 1) ? $clog2(OVS) : 1;

  logic [CNT_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic              ext;
  logic [OS_W-1:0]   os_cnt;

  logic [CNT_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [CNT_W-1:0]  pend_int;
  logic [FRAC_W-1:0] pend_frac;
  logic              pend_vld;

  logic [CNT_W:0]    end_val;
  logic              period_end;
  logic [FRAC_W:0]   acc_sum;
  logic              wr_bad;
  logic              wr_valid;

  // The carry from the phase accumulator stretches the next period by one cycle.
  assign end_val    = {1'b0, act_int} + {{CNT_W{1'b0}}, ext} - {{CNT_W{1'b0}}, 1'b1};
  assign period_end = ({1'b0, cnt} == end_val);
  assign os_tick    = en & period_end;
  assign baudtick   = os_tick & (os_cnt == OS_W'(OVS - 1));
  assign acc_sum    = {1'b0, acc} + {1'b0, act_frac};
  assign div_active = act_int;

  // div_wr is a one-cycle strobe with no back-pressure: a write is always
  // accepted (or rejected via div_err) in the cycle it is presented.
  assign wr_bad   = div_wr & (div_int < CNT_W'(2));
  assign wr_valid = div_wr & ~wr_bad;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      acc    <= '0;
      ext    <= 1'b0;
      os_cnt <= '0;
    end else if (!en) begin
      cnt    <= '0;
      acc    <= '0;
      ext    <= 1'b0;
      os_cnt <= '0;
    end else if (os_tick) begin
      cnt          <= '0;
      {ext, acc}   <= acc_sum;
      os_cnt       <= (os_cnt == OS_W'(OVS - 1)) ? '0 : os_cnt + OS_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // New divisors only take effect on a period boundary (or immediately when idle).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      act_int   <= CNT_W'(RESET_DIV);
      act_frac  <= FRAC_W'(RESET_FRAC);
      pend_int  <= '0;
      pend_frac <= '0;
      pend_vld  <= 1'b0;
      div_err   <= 1'b0;
    end else begin
      div_err <= wr_bad;
      if (wr_valid && (!en || os_tick)) begin
        act_int  <= div_int;
        act_frac <= div_frac;
        pend_vld <= 1'b0;
      end else if (wr_valid) begin
        pend_int  <= div_int;
        pend_frac <= div_frac;
        pend_vld  <= 1'b1;
      end else if (os_tick && pend_vld) begin
        act_int  <= pend_int;
        act_frac <= pend_frac;
        pend_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: phase table, directed divisor-update sequences and a
// randomized run, all checked cycle by cycle against a period-length model.
module tb_baud_gen_frac;

  localparam int CNT_W     = 16;
  localparam int FRAC_W    = 4;
  localparam int OVS       = 16;
  localparam int RESET_DIV = 163;
  localparam int FRAC_MOD  = 1 << FRAC_W;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              en = 1'b0;
  logic              div_wr = 1'b0;
  logic [CNT_W-1:0]  div_int = '0;
  logic [FRAC_W-1:0] div_frac = '0;
  logic              os_tick;
  logic              baudtick;
  logic [CNT_W-1:0]  div_active;
  logic              div_err;

  baud_gen_frac #(
    .CNT_W(CNT_W), .FRAC_W(FRAC_W), .OVS(OVS), .RESET_DIV(RESET_DIV), .RESET_FRAC(0)
  ) dut (
    .clk(clk), .resetn(resetn), .en(en), .div_wr(div_wr), .div_int(div_int),
    .div_frac(div_frac), .os_tick(os_tick), .baudtick(baudtick),
    .div_active(div_active), .div_err(div_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  bit seen_tick, seen_baud, seen_err;

  // Reference model: a period lasts (divisor + carry) enabled cycles, where the
  // carry comes from summing the fractional part modulo 2^FRAC_W at each tick.
  int m_int, m_frac, m_pint, m_pfrac, m_pos, m_acc, m_ticks;
  bit m_pvld, m_ext, m_err;

  task automatic model_reset();
    m_int = RESET_DIV; m_frac = 0; m_pint = 0; m_pfrac = 0; m_pvld = 1'b0;
    m_pos = 0; m_acc = 0; m_ext = 1'b0; m_ticks = 0; m_err = 1'b0;
  endtask

  function automatic bit model_tick_now(bit e);
    return e && (m_pos + 1 == m_int + int'(m_ext));
  endfunction

  task automatic model_update(bit e, bit w, int di, int df, bit t);
    int s;
    if (!e) begin
      m_pos = 0; m_acc = 0; m_ext = 1'b0; m_ticks = 0;
    end else if (t) begin
      s = m_acc + m_frac;
      m_ext = (s >= FRAC_MOD);
      m_acc = s % FRAC_MOD;
      m_pos = 0;
      m_ticks = (m_ticks + 1) % OVS;
    end else begin
      m_pos++;
    end
    m_err = w && (di < 2);
    if (w && di >= 2 && (!e || t)) begin
      m_int = di; m_frac = df; m_pvld = 1'b0;
    end else if (w && di >= 2) begin
      m_pint = di; m_pfrac = df; m_pvld = 1'b1;
    end else if (t && m_pvld) begin
      m_int = m_pint; m_frac = m_pfrac; m_pvld = 1'b0;
    end
  endtask

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: one clock cycle, inputs driven on the falling edge
  task automatic step(bit rn, bit e, bit w, int di, int df);
    bit t_exp, b_exp;
    @(negedge clk);
    resetn = rn; en = e; div_wr = w; div_int = CNT_W'(di); div_frac = FRAC_W'(df);
    if (!rn) model_reset();
    #1;
    t_exp = rn && model_tick_now(e);
    b_exp = t_exp && (m_ticks == OVS - 1);
    check("os_tick", int'(os_tick), int'(t_exp));
    check("baudtick", int'(baudtick), int'(b_exp));
    check("div_active", int'(div_active), m_int);
    check("div_err", int'(div_err), int'(m_err));
    seen_tick = os_tick; seen_baud = baudtick; seen_err = div_err;
    if (rn) model_update(e, w, di, df, t_exp);
    cyc++;
    @(posedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic run_until_tick(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      step(1'b1, 1'b1, 1'b0, 0, 0);
      n++;
      if (seen_tick) return;
    end
    n_vec++; n_fail++;
    $display("FAIL tick_timeout: no os_tick within 400 cycles (cycle %0d)", cyc);
  endtask

  typedef struct {
    bit en; bit wr; int di; int df; int cycles;
    int exp_ticks; int exp_bauds; int exp_active;
  } phase_t;

  phase_t ph [0:6];

  initial begin
    int n, nt, nb;
    ph[0] = '{1'b0, 1'b0, 0,  0, 2,    0,  0, 163};
    ph[1] = '{1'b1, 1'b0, 0,  0, 2608, 16, 1, 163};
    ph[2] = '{1'b0, 1'b0, 0,  0, 3,    0,  0, 163};
    ph[3] = '{1'b0, 1'b1, 10, 8, 1,    0,  0, 10};
    ph[4] = '{1'b1, 1'b0, 0,  0, 52,   5,  0, 10};
    ph[5] = '{1'b1, 1'b0, 0,  0, 10,   1,  0, 10};
    ph[6] = '{1'b1, 1'b1, 1,  0, 11,   1,  0, 10};

    model_reset();
    step(1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0);
    check("reset_div_active", int'(div_active), 163);
    check("reset_os_tick", int'(os_tick), 0);
    check("reset_baudtick", int'(baudtick), 0);
    check("reset_div_err", int'(div_err), 0);

    for (int p = 0; p < 7; p++) begin
      nt = 0; nb = 0;
      for (int c = 0; c < ph[p].cycles; c++) begin
        step(1'b1, ph[p].en, ph[p].wr && (c == 0), ph[p].di, ph[p].df);
        if (seen_tick) nt++;
        if (seen_baud) nb++;
      end
      #2;
      check($sformatf("phase%0d_ticks", p), nt, ph[p].exp_ticks);
      check($sformatf("phase%0d_bauds", p), nb, ph[p].exp_bauds);
      check($sformatf("phase%0d_active", p), int'(div_active), ph[p].exp_active);
    end

    // reset mid-period discards a pending write
    step(1'b1, 1'b1, 1'b1, 20, 0);
    idle(3);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 0, 0);
      check("tick_in_reset", int'(seen_tick), 0);
    end
    check("active_after_reset", int'(div_active), 163);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    run_until_tick(n); check("first_after_reset", n, 163);
    run_until_tick(n); check("pending_discarded", n, 163);

    // rejected write
    step(1'b1, 1'b1, 1'b1, 1, 0);
    step(1'b1, 1'b1, 1'b0, 0, 0); check("err_pulse", int'(seen_err), 1);
    step(1'b1, 1'b1, 1'b0, 0, 0); check("err_one_cycle", int'(seen_err), 0);
    check("active_after_bad", int'(div_active), 163);
    run_until_tick(n); check("bad_remaining", n, 160);
    run_until_tick(n); check("bad_spacing", n, 163);

    // write 50 at cnt=20
    idle(20);
    step(1'b1, 1'b1, 1'b1, 50, 0);
    check("active_before_boundary", int'(div_active), 163);
    run_until_tick(n); check("period_completes", n, 142);
    #2 check("active_on_boundary", int'(div_active), 50);
    run_until_tick(n); check("new_period_1", n, 50);
    run_until_tick(n); check("new_period_2", n, 50);

    // last write wins
    idle(5);
    step(1'b1, 1'b1, 1'b1, 40, 0);
    idle(5);
    step(1'b1, 1'b1, 1'b1, 60, 0);
    run_until_tick(n); check("lww_remaining", n, 38);
    run_until_tick(n); check("lww_period", n, 60);

    // write coincident with os_tick
    for (int i = 0; i < 200; i++) begin
      if (model_tick_now(1'b1)) break;
      step(1'b1, 1'b1, 1'b0, 0, 0);
    end
    step(1'b1, 1'b1, 1'b1, 30, 0);
    check("wr_on_tick", int'(seen_tick), 1);
    run_until_tick(n); check("bypass_period", n, 30);

    // en dropped mid-period
    idle(10);
    nt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 0, 0);
      if (seen_tick) nt++;
    end
    check("no_tick_en_low", nt, 0);
    run_until_tick(n); check("first_after_en", n, 30);

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 499) != 0), ($urandom_range(0, 49) != 0),
           ($urandom_range(0, 19) == 0), int'($urandom_range(0, 12)),
           int'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
